// File: rtl/bias_fetch_unit.sv
// -----------------------------------------------------------------------------
// bias_fetch_unit
//
// Sequencer between the layer controller and the bias ROM. A start command
// walks one layer's contiguous span of bias entries and delivers them as a
// valid/ready stream. The ROM has a 1-cycle synchronous read latency and
// returns zero when not enabled, so every read is tracked by an inflight flag
// until its word lands in a 2-entry FIFO. Reads are only issued when the FIFO
// is guaranteed to have room for them, so downstream backpressure never loses
// or duplicates a word.
//
// Optional feature: define BIAS_FETCH_ABORT_EN to add the abort input, which
// flushes an active span and returns to IDLE without a done pulse.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   start             command strobe, accepted only in IDLE
//   base_addr [AW]    first ROM address of the span
//   count     [AW+1]  number of biases to fetch
//   busy              high from accepted start until the last beat handshakes
//   done              one-cycle pulse on the last beat's handshake
//                     (or the cycle after a count==0 start)
//   cfg_error         one-cycle pulse when a start runs past the ROM end
//   rom_read_enable   ROM read request
//   rom_addr  [AW]    ROM address (0 when no read)
//   rom_bias_out      ROM data, valid the cycle after rom_read_enable
//   bias_valid/ready  output stream handshake
//   bias_data         bias word at the FIFO head
//   bias_last         marks the final beat of the span
//   abort             (BIAS_FETCH_ABORT_EN only) flush the active span
// -----------------------------------------------------------------------------
module bias_fetch_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 240,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      count,
`ifdef BIAS_FETCH_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             cfg_error,
  output logic             rom_read_enable,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_bias_out,
  output logic             bias_valid,
  input  logic             bias_ready,
  output logic [WIDTH-1:0] bias_data,
  output logic             bias_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  state_t           state;
  logic [AW-1:0]    base_q;
  logic [AW:0]      count_q;
  logic [AW:0]      issued_q;
  logic             inflight_q;
  logic             inflight_last_q;
  logic             done_q;
  logic             cfg_error_q;

  // 2-entry FIFO: storage, pointers and occupancy
  logic [WIDTH-1:0] fifo_data [2];
  logic             fifo_last [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       occ;

  logic             abort_hit;
  logic             pop;
  logic             push;
  logic             issue;
  logic             credit_ok;
  logic [2:0]       credit_sum;
  logic             last_beat;
  logic [AW:0]      issued_next;
  logic [AW+1:0]    span_end;
  logic             span_over;

`ifdef BIAS_FETCH_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Stream side: the FIFO head is the output beat.
  assign bias_valid = (occ != 2'd0);
  assign bias_data  = fifo_data[rd_ptr];
  assign bias_last  = bias_valid && fifo_last[rd_ptr];
  assign pop        = bias_valid && bias_ready;
  assign last_beat  = pop && bias_last;

  // The word read last cycle arrives now; an abort drops it.
  assign push = inflight_q && !abort_hit;

  // Room check counts the word still in the ROM pipeline and credits a pop
  // happening this very cycle, so the FIFO can never be asked to hold 3.
  assign credit_sum = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok  = (credit_sum < 3'd2);

  assign issue       = (state == S_FETCH) && credit_ok && !abort_hit;
  assign issued_next = issued_q + 1'b1;

  assign rom_read_enable = issue;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rom_addr = '0;
    if (issue) begin
      rom_addr = base_q + issued_q[AW-1:0];
    end
  end

  // Range check widened by two bits so base+count cannot wrap.
  assign span_end  = {2'b00, base_addr} + {1'b0, count};
  assign span_over = (span_end > DEPTH_W);

  assign busy      = (state != S_IDLE);
  assign done      = done_q || (last_beat && !abort_hit);
  assign cfg_error = cfg_error_q;

  // Control FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      base_q          <= '0;
      count_q         <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      cfg_error_q     <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      cfg_error_q     <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (issued_next == count_q);

      case (state)
        S_IDLE: begin
          if (start) begin
            if (count == '0) begin
              done_q <= 1'b1;
            end else if (span_over) begin
              cfg_error_q <= 1'b1;
            end else begin
              base_q   <= base_addr;
              count_q  <= count;
              issued_q <= '0;
              state    <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (abort_hit) begin
            state <= S_IDLE;
          end else if (issue) begin
            issued_q <= issued_next;
            if (issued_next == count_q) begin
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (abort_hit || last_beat) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO datapath
  // NOTE: the two storage entries are reset because bias_data is a direct
  // view of the head entry and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (abort_hit) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= rom_bias_out;
        fifo_last[wr_ptr] <= inflight_last_q;
        wr_ptr            <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_bias_fetch_unit
//
// Self-checking bench for bias_fetch_unit. A behavioural ROM (1-cycle latency,
// zero when not enabled) is filled with random words; each span's expected
// beat sequence is simply rom_mem[base+k] for k = 0..count-1 with last on the
// final index. Spans run with constant, patterned and random backpressure.
// Define BIAS_FETCH_ABORT_EN to also exercise the abort port.
// -----------------------------------------------------------------------------
module tb_bias_fetch_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 240;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic             cfg_error;
  logic             rom_read_enable;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_bias_out;
  logic             bias_valid;
  logic             bias_ready;
  logic [WIDTH-1:0] bias_data;
  logic             bias_last;
`ifdef BIAS_FETCH_ABORT_EN
  logic             abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bias_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .count           (count),
`ifdef BIAS_FETCH_ABORT_EN
    .abort           (abort),
`endif
    .busy            (busy),
    .done            (done),
    .cfg_error       (cfg_error),
    .rom_read_enable (rom_read_enable),
    .rom_addr        (rom_addr),
    .rom_bias_out    (rom_bias_out),
    .bias_valid      (bias_valid),
    .bias_ready      (bias_ready),
    .bias_data       (bias_data),
    .bias_last       (bias_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM: synchronous read, output zero when not enabled.
  logic [WIDTH-1:0] rom_mem [DEPTH];
  logic [WIDTH-1:0] rom_q = '0;
  int unsigned      total_reads = 0;

  always @(posedge clk) begin
    if (rom_read_enable) begin
      rom_q       <= rom_mem[rom_addr];
      total_reads <= total_reads + 1;
    end else begin
      rom_q <= '0;
    end
  end
  assign rom_bias_out = rom_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_err",   cfg_error, 0);
    check("rst_ren",   rom_read_enable, 0);
    check("rst_addr",  rom_addr, 0);
    check("rst_valid", bias_valid, 0);
    check("rst_data",  bias_data, 0);
    check("rst_last",  bias_last, 0);
  endtask

  function automatic logic ready_pattern(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc - 1) % 3) == 0;   // 1,0,0,1,0,0,...
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Run one accepted span and check every cycle against the reference:
  // beat k must be rom_mem[base+k], reads go out in address order, and the
  // words outstanding (read but not yet accepted) never exceed 2.
  task automatic run_span(input int base, input int n, input int mode, input bit timing);
    int  snap;
    int  pops;
    int  issued;
    int  first_cyc;
    int  done_cyc;
    int  budget;
    bit  fin;
    bit  pop_now;
    pops      = 0;
    first_cyc = -1;
    done_cyc  = -1;
    fin       = 1'b0;
    budget    = 6 * n + 20;

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    count     = (AW+1)'(n);
    @(posedge clk);
    snap = total_reads;
    #1 start = 1'b0;

    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      bias_ready = ready_pattern(mode, cyc);
      @(negedge clk);
      issued  = total_reads - snap;
      pop_now = bias_valid && bias_ready;
      check("span_busy", busy, 1);
      if (rom_read_enable) begin
        check("read_addr", rom_addr, base + issued);
        check("read_extra", issued < n, 1);
        check("credit", (issued - pops + 1 - int'(pop_now)) <= 2, 1);
      end else begin
        check("idle_addr", rom_addr, 0);
      end
      if (pop_now) begin
        if (pops == 0) first_cyc = cyc;
        check("beat_data", bias_data, rom_mem[base + pops]);
        check("beat_last", bias_last, pops == n - 1);
        pops++;
      end
      check("done_pulse", done, pop_now && (pops == n));
      if (done) begin
        fin      = 1'b1;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end

    if (!fin) check("span_timeout", 0, 1);
    check("beat_count", pops, n);
    check("read_count", total_reads - snap, n);
    if (timing) begin
      check("first_beat_cycle", first_cyc, 3);
      check("done_cycle", done_cyc, n + 2);
    end
    @(negedge clk);
    check("post_busy",  busy, 0);
    check("post_valid", bias_valid, 0);
    check("post_done",  done, 0);
    bias_ready = 1'b1;
  endtask

  // A start that is not accepted: cfg_error (range) or done (count==0) pulse
  // once in cycle 1 and the ROM is never touched.
  task automatic run_reject(input int base, input int n, input bit expect_err);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    count     = (AW+1)'(n);
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      check("rej_ren",   rom_read_enable, 0);
      check("rej_busy",  busy, 0);
      check("rej_valid", bias_valid, 0);
      check("rej_err",   cfg_error, (cyc == 1) && expect_err);
      check("rej_done",  done, (cyc == 1) && !expect_err);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int base;
    int n;

    for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    count      = '0;
    bias_ready = 1'b1;
`ifdef BIAS_FETCH_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed spans
    run_span(10, 4, 0, 1'b1);
    run_span(10, 4, 1, 1'b0);
    run_reject(238, 3, 1'b1);
    run_reject(5, 0, 1'b0);
    run_span(237, 3, 0, 1'b1);        // ends exactly at DEPTH
    run_span(0, DEPTH, 0, 1'b1);

    // Reset mid-span after two beats of a count=8 span
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(40);
    count     = (AW+1)'(8);
    @(posedge clk);
    #1 start = 1'b0;
    pops = 0;
    for (int cyc = 1; cyc <= 20 && pops < 2; cyc++) begin
      @(negedge clk);
      if (bias_valid && bias_ready) begin
        check("pre_rst_data", bias_data, rom_mem[40 + pops]);
        pops++;
      end
    end
    check("pre_rst_beats", pops, 2);
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    @(posedge clk);
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    run_span(40, 8, 0, 1'b1);

`ifdef BIAS_FETCH_ABORT_EN
    // Abort during the first beat of a count=6 span
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(100);
    count     = (AW+1)'(6);
    @(posedge clk);
    #1 start = 1'b0;
    pops = 0;
    for (int cyc = 1; cyc <= 20 && pops < 1; cyc++) begin
      @(negedge clk);
      if (bias_valid && bias_ready) pops++;
    end
    check("pre_abort_beat", pops, 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      check("abort_busy",  busy, 0);
      check("abort_valid", bias_valid, 0);
      check("abort_done",  done, 0);
      check("abort_ren",   rom_read_enable, 0);
    end
    run_span(100, 6, 0, 1'b1);
`endif

    // Random spans with random backpressure
    for (int t = 0; t < 8; t++) begin
      n    = $urandom_range(1, 24);
      base = $urandom_range(0, DEPTH - n);
      run_span(base, n, 2, 1'b0);
    end
    run_span(DEPTH - 5, 5, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
